// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch unit with a small in-order fetch buffer.
//
// Issues one instruction-memory request at a time, captures the response
// into a DEPTH-entry FIFO and presents the oldest entry to decode. Requests
// are only issued while the FIFO has room for the response, so it never
// overflows. A redirect flushes the FIFO, retargets the PC and drops the
// response of any request already in flight.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned byte address
//   imem_ready        memory accepts the request on a rising edge
//   imem_rvalid/rdata response to the single outstanding request
//   redirect_valid/pc one-cycle branch/jump redirect and its target
//   if_valid/ready    decode handshake on the FIFO head
//   if_pc/if_instr    PC and instruction word of the FIFO head
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [31:0]       pc_q;
  logic [31:0]       req_pc_q;
  logic              discard_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [31:0]       buf_pc    [DEPTH];
  logic [31:0]       buf_instr [DEPTH];

  logic              accept, rsp, push, pop;
  logic [31:0]       redirect_tgt;

  // FIFO pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign accept       = imem_req & imem_ready;
  assign rsp          = (state_q == S_WAIT) & imem_rvalid;
  // Redirect dominates: a response on the redirect edge is dropped and the
  // head is not consumed because the whole FIFO is being flushed.
  assign push         = rsp & ~discard_q & ~redirect_valid;
  assign pop          = if_valid & if_ready & ~redirect_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (accept)      state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_REQ;
      default:                  state_d = S_REQ;
    endcase
  end

  // Output logic; run_q holds the request low until the first edge out of reset
  always_comb begin
    imem_req  = run_q && (state_q == S_REQ) && (count_q < FULL_CNT);
    imem_addr = pc_q;
    if_valid  = (count_q != '0);
    if_pc     = buf_pc[rd_ptr_q];
    if_instr  = buf_instr[rd_ptr_q];
  end

  // PC, in-flight bookkeeping and fetch FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      pc_q      <= RESET_PC & 32'hFFFF_FFFC;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;

      // A redirect wins over the increment even when a request is accepted
      // on the same edge; that request is discarded below.
      if (redirect_valid)  pc_q <= redirect_tgt;
      else if (accept)     pc_q <= pc_q + 32'd4;

      if (accept) req_pc_q <= pc_q;

      // Discard marks the one in-flight request as stale; it clears exactly
      // when that response is dropped, so repeated redirects drop it once.
      if (rsp)
        discard_q <= 1'b0;
      else if (redirect_valid && ((state_q == S_WAIT) || accept))
        discard_q <= 1'b1;

      if (redirect_valid) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          buf_pc[wr_ptr_q]    <= req_pc_q;
          buf_instr[wr_ptr_q] <= imem_rdata;
          wr_ptr_q            <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule
